mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles in BUSY awaiting m_ack before abort.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch request; held until i_ack.
REQ-006 i_addr  in  32  instruction fetch byte address.
REQ-007 i_rdata  out  32  fetched word; valid while i_ack=1.
REQ-008 i_ack  out  1  one-cycle completion pulse, instruction port.
REQ-009 d_req  in  1  data request; held until d_ack.
REQ-010 d_we  in  1  1=store (SW), 0=load (LW).
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_rdata  out  32  load data; valid while d_ack=1.
REQ-014 d_ack  out  1  one-cycle completion pulse, data port.
REQ-015 m_req  out  1  request to shared unified memory.
REQ-016 m_we  out  1  memory write enable.
REQ-017 m_addr  out  32  memory address.
REQ-018 m_wdata  out  32  memory write data.
REQ-019 m_rdata  in  32  memory read data; valid when m_ack=1.
REQ-020 m_ack  in  1  memory completion, may assert in the first m_req cycle.
REQ-021 err  out  1  one-cycle pulse coincident with the ack of a timed-out transaction.

Function
REQ-022 FSM states: IDLE, BUSY, RESP; transitions only on posedge clk.
REQ-023 IDLE: no req -> stay; any req -> select requester, latch addr/we/wdata into m_* regs, -> BUSY.
REQ-024 Selection: single requester wins; both requesting -> port not granted last (round-robin bit last_grant).
REQ-025 last_grant updates on every IDLE->BUSY transition to the selected port.
REQ-026 Instruction grant drives m_we=0, m_wdata unchanged.
REQ-027 BUSY: m_req=1; m_addr/m_we/m_wdata constant for the whole BUSY stay.
REQ-028 BUSY with m_ack=1 -> capture m_rdata into selected port's rdata reg, -> RESP.
REQ-029 BUSY timer counts cycles in BUSY from 1; m_ack absent at count TIMEOUT -> rdata=ERR_DATA, err=1 in RESP, -> RESP.
REQ-030 m_ack and timeout in the same cycle -> m_ack wins, err=0.
REQ-031 RESP: selected port's ack=1 for exactly one cycle, m_req=0, -> IDLE; requests ignored in RESP.
REQ-032 Zero-wait memory: req sampled cycle N, m_req cycle N+1, ack cycle N+2; back-to-back throughput one transaction per 3 cycles.
REQ-033 i_ack and d_ack never high in the same cycle; m_req=0 in IDLE and RESP.
REQ-034 Store completion: d_ack pulses, d_rdata unchanged (holds last load value) unless timed out.
REQ-035 m_ack seen outside BUSY is ignored.
REQ-036 rdata regs hold value between acks.

Reset
REQ-037 reset=1 asynchronously forces: state=IDLE, last_grant=data (first tie grants instruction), timer=0.
REQ-038 Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, i_ack=0, d_ack=0, err=0.
REQ-039 Reset mid-BUSY or mid-RESP abandons the transaction, no ack issued; requester re-requests.

Structure
REQ-040 Shared package mem_arb_pkg holds state enum, port-id encoding (PORT_I=0, PORT_D=1), default TIMEOUT and ERR_DATA.
REQ-041 One sub-module, mem_arb_timer: clear/enable inputs, expired output at TIMEOUT; arbitration and FSM stay in mem_arbiter.

Verification
REQ-042 i_req only, addr 0x40, memory acks first cycle with 0x2002000A -> i_ack cycle N+2, i_rdata=0x2002000A, err=0.
REQ-043 i_req and d_req (load 0x100, mem 0x55) same cycle after reset -> instruction served first, then data; d_rdata=0x55; next tie grants instruction.
REQ-044 d_req store, addr 0x200, wdata 0x1234, memory 3 wait cycles -> m_we=1, m_addr/m_wdata stable 4 BUSY cycles, d_ack once.
REQ-045 Memory never acks, TIMEOUT=16 -> d_ack and err pulse together 17 cycles after request, d_rdata=0xDEADBEEF, then IDLE.
REQ-046 reset asserted during BUSY -> all outputs to reset values immediately, no ack; new i_req afterward completes normally.
REQ-047 m_ack arrives in timer cycle 16 -> normal completion, err=0, rdata=m_rdata.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   state_t     : arbiter FSM states (IDLE, BUSY, RESP)
//   port_t      : requester encoding (PORT_I = 0, PORT_D = 1)
//   DEF_TIMEOUT : default number of BUSY cycles before a transaction is aborted
//   DEF_ERR_DATA: default read data returned by an aborted transaction
//   pick_port   : round-robin selection between the two requesters
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int unsigned DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // A lone requester always wins; on a tie the port that was not granted
    // last goes next.
    function automatic port_t pick_port(input logic i_req, input logic d_req,
                                        input port_t last_grant);
        if (i_req && d_req) begin
            return (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            return PORT_D;
        end else begin
            return PORT_I;
        end
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle for the memory arbiter: instruction-fetch port (i_*), data
// port (d_*), shared memory port (m_*) and the timeout error pulse.
//   slave  : arbiter view (takes client requests, drives the memory port)
//   master : environment view (clients plus memory model)
interface mem_arb_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog counter.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : force the count back to zero
//   en         : advance the count by one
//   expired    : high while the count equals TIMEOUT
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single unified memory.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : mem_arb_if.slave -- instruction port, data port, memory
//                port and err pulse
// One transaction at a time: IDLE picks a requester and latches its command,
// BUSY waits for m_ack (or the timeout), RESP pulses the requester's ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.slave  bus
);

    state_t      state_q, state_d;
    port_t       sel_q, sel_d;
    port_t       last_grant_q, last_grant_d;
    logic        timed_out_q, timed_out_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        tmr_en;
    logic        tmr_expired;
    port_t       pick;

    // Timer runs from the IDLE->BUSY edge through every cycle that stays in
    // BUSY, so it reads 1 in the first BUSY cycle; it is cleared otherwise.
    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!tmr_en),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        timed_out_d  = timed_out_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        tmr_en       = 1'b0;
        pick         = pick_port(bus.i_req, bus.d_req, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d      = ST_BUSY;
                    sel_d        = pick;
                    last_grant_d = pick;
                    timed_out_d  = 1'b0;
                    tmr_en       = 1'b1;
                    if (pick == PORT_I) begin
                        // Fetches never write; m_wdata keeps its old value.
                        m_addr_d = bus.i_addr;
                        m_we_d   = 1'b0;
                    end else begin
                        m_addr_d  = bus.d_addr;
                        m_we_d    = bus.d_we;
                        m_wdata_d = bus.d_wdata;
                    end
                end
            end
            ST_BUSY: begin
                // m_ack takes priority over a timeout in the same cycle.
                if (bus.m_ack) begin
                    state_d = ST_RESP;
                    if (sel_q == PORT_I) begin
                        i_rdata_d = bus.m_rdata;
                    end else if (!m_we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end else if (tmr_expired) begin
                    state_d     = ST_RESP;
                    timed_out_d = 1'b1;
                    if (sel_q == PORT_I) begin
                        i_rdata_d = ERR_DATA;
                    end else begin
                        d_rdata_d = ERR_DATA;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= PORT_I;
            last_grant_q <= PORT_D;
            timed_out_q  <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            timed_out_q  <= timed_out_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Handshake outputs decode straight from registered state, so they drop
    // the moment reset is asserted.
    assign bus.m_req   = (state_q == ST_BUSY);
    assign bus.i_ack   = (state_q == ST_RESP) && (sel_q == PORT_I);
    assign bus.d_ack   = (state_q == ST_RESP) && (sel_q == PORT_D);
    assign bus.err     = (state_q == ST_RESP) && timed_out_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int unsigned TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_arb_if bus ();

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    // mode 0: wait = addr[3:2] cycles, data = hash(addr)
    // mode 1: fixed wait/data; mode 2: never acknowledges
    int          mem_mode  = 1;
    int          fix_wait  = 0;
    logic [31:0] fix_data  = 32'h0;
    logic        stray_ack = 1'b0;
    int          req_cycles = 0;
    int          cur_wait;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    always @(posedge clk) begin
        req_cycles <= (bus.m_req && !bus.m_ack) ? req_cycles + 1 : 0;
    end

    always_comb begin
        cur_wait    = (mem_mode == 0) ? int'(bus.m_addr[3:2]) : fix_wait;
        bus.m_rdata = (mem_mode == 0) ? mem_word(bus.m_addr) : fix_data;
        bus.m_ack   = stray_ack || (bus.m_req && (mem_mode != 2) && (req_cycles == cur_wait));
    end

    // ---------------- bus monitor ----------------
    int          both_ack_cnt = 0;
    int          overlap_cnt  = 0;
    int          unstable_cnt = 0;
    logic        prev_mreq    = 1'b0;
    logic [64:0] prev_cmd     = '0;
    logic [64:0] grant_q [$];

    always @(negedge clk) begin
        if (bus.i_ack && bus.d_ack) both_ack_cnt++;
        if ((bus.i_ack || bus.d_ack) && bus.m_req) overlap_cnt++;
        if (bus.m_req && prev_mreq && ({bus.m_we, bus.m_addr, bus.m_wdata} != prev_cmd)) unstable_cnt++;
        if (bus.m_req && !prev_mreq) grant_q.push_back({bus.m_we, bus.m_addr, bus.m_wdata});
        prev_mreq = bus.m_req;
        prev_cmd  = {bus.m_we, bus.m_addr, bus.m_wdata};
    end

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        grant_q.delete();
    endtask

    // Returns the number of falling edges until an ack and which ack(s):
    // 1 = instruction, 2 = data, 3 = both, 0 = none within the limit.
    task automatic wait_any_ack(input int limit, output int lat, output int which);
        lat = 0;
        which = 0;
        while (which == 0 && lat < limit) begin
            @(negedge clk);
            lat++;
            which = int'({bus.d_ack, bus.i_ack});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got %b want 0", bus.m_req); end
        checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we got %b want 0", bus.m_we); end
        checks++; if (bus.m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got %h want 0", bus.m_addr); end
        checks++; if (bus.m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata got %h want 0", bus.m_wdata); end
        checks++; if (bus.i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata got %h want 0", bus.i_rdata); end
        checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h want 0", bus.d_rdata); end
        checks++; if ({bus.i_ack, bus.d_ack, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b want 000", {bus.i_ack, bus.d_ack, bus.err}); end
        reset = 1'b0;
        grant_q.delete();
    endtask

    task automatic test_fetch();
        int lat, which;
        logic [64:0] rec;
        mem_mode = 1; fix_wait = 0; fix_data = 32'h2002000A;
        bus.i_addr = 32'h40; bus.i_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 1) begin errors++; $display("FAIL fetch_port got %0d want 1", which); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL fetch_latency got %0d want 2", lat); end
        checks++; if (bus.i_rdata !== 32'h2002000A) begin errors++; $display("FAIL fetch_rdata got %h want 2002000a", bus.i_rdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fetch_err got %b want 0", bus.err); end
        bus.i_req = 1'b0;
        rec = (grant_q.size() > 0) ? grant_q.pop_front() : 'x;
        checks++; if (rec !== {1'b0, 32'h40, 32'h0}) begin errors++; $display("FAIL fetch_cmd got %h want %h", rec, {1'b0, 32'h40, 32'h0}); end
        @(negedge clk);
        checks++; if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_width got %b want 0", bus.i_ack); end
    endtask

    task automatic test_tie();
        int lat, which;
        logic [64:0] rec;
        apply_reset();
        mem_mode = 1; fix_wait = 0; fix_data = 32'h55;
        bus.i_addr = 32'h80; bus.i_req = 1'b1;
        bus.d_addr = 32'h100; bus.d_we = 1'b0; bus.d_wdata = 32'h0; bus.d_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 1 || lat !== 2) begin errors++; $display("FAIL tie_first got port %0d lat %0d want port 1 lat 2", which, lat); end
        bus.i_req = 1'b0;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 2 || lat !== 3) begin errors++; $display("FAIL tie_second got port %0d lat %0d want port 2 lat 3", which, lat); end
        checks++; if (bus.d_rdata !== 32'h55) begin errors++; $display("FAIL tie_d_rdata got %h want 00000055", bus.d_rdata); end
        bus.d_req = 1'b0;
        void'(grant_q.pop_front());
        rec = (grant_q.size() > 0) ? grant_q.pop_front() : 'x;
        checks++; if (rec !== {1'b0, 32'h100, 32'h0}) begin errors++; $display("FAIL tie_d_cmd got %h want %h", rec, {1'b0, 32'h100, 32'h0}); end
        @(negedge clk);
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 1) begin errors++; $display("FAIL tie_next_grant got %0d want 1", which); end
        bus.i_req = 1'b0;
        wait_any_ack(40, lat, which);
        bus.d_req = 1'b0;
        grant_q.delete();
        @(negedge clk);
    endtask

    task automatic test_store_wait();
        int busy = 0, bad = 0, acks = 0, ack_lat = 0;
        logic [31:0] rd = 'x;
        logic e = 1'bx;
        mem_mode = 1; fix_wait = 3; fix_data = 32'h77777777;
        bus.d_addr = 32'h200; bus.d_wdata = 32'h1234; bus.d_we = 1'b1; bus.d_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.m_req) begin
                busy++;
                if (bus.m_we !== 1'b1 || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h1234) bad++;
            end
            if (bus.d_ack) begin
                acks++; ack_lat = k; rd = bus.d_rdata; e = bus.err;
                bus.d_req = 1'b0;
            end
        end
        checks++; if (busy !== 4) begin errors++; $display("FAIL store_busy_cycles got %0d want 4", busy); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL store_cmd_stable got %0d bad cycles want 0", bad); end
        checks++; if (acks !== 1 || ack_lat !== 5) begin errors++; $display("FAIL store_ack got %0d acks at %0d want 1 at 5", acks, ack_lat); end
        checks++; if (rd !== 32'h55) begin errors++; $display("FAIL store_d_rdata_hold got %h want 00000055", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", e); end
        grant_q.delete();
    endtask

    task automatic test_timeout();
        int lat, which;
        mem_mode = 2;
        bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 2 || lat !== 17) begin errors++; $display("FAIL timeout_ack got port %0d lat %0d want port 2 lat 17", which, lat); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", bus.err); end
        checks++; if (bus.d_rdata !== ERRD) begin errors++; $display("FAIL timeout_rdata got %h want %h", bus.d_rdata, ERRD); end
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++; if ({bus.err, bus.d_ack, bus.m_req} !== 3'b000) begin errors++; $display("FAIL timeout_after got %b want 000", {bus.err, bus.d_ack, bus.m_req}); end
        grant_q.delete();
    endtask

    task automatic test_ack_at_limit();
        int lat, which;
        logic e;
        mem_mode = 1; fix_wait = 15; fix_data = 32'hCAFE0047;
        bus.i_addr = 32'h47C; bus.i_req = 1'b1;
        wait_any_ack(40, lat, which);
        e = bus.err;
        checks++; if (which !== 1 || lat !== 17) begin errors++; $display("FAIL limit_ack got port %0d lat %0d want port 1 lat 17", which, lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL limit_err got %b want 0", e); end
        checks++; if (bus.i_rdata !== 32'hCAFE0047) begin errors++; $display("FAIL limit_rdata got %h want cafe0047", bus.i_rdata); end
        bus.i_req = 1'b0;
        grant_q.delete();
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        int seen = 0;
        int lat, which;
        stray_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack || bus.m_req || bus.err) seen++;
        end
        stray_ack = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL stray_ack_activity got %0d cycles want 0", seen); end
        checks++; if (bus.i_rdata !== 32'hCAFE0047) begin errors++; $display("FAIL stray_i_rdata_hold got %h want cafe0047", bus.i_rdata); end
        mem_mode = 1; fix_wait = 0; fix_data = 32'h00005A5A;
        bus.i_addr = 32'h50; bus.i_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 1 || lat !== 2 || bus.i_rdata !== 32'h00005A5A) begin errors++; $display("FAIL stray_next_fetch got port %0d lat %0d data %h want 1 2 00005a5a", which, lat, bus.i_rdata); end
        bus.i_req = 1'b0;
        grant_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        int acks = 0;
        int lat, which;
        mem_mode = 1; fix_wait = 5; fix_data = 32'h11112222;
        bus.d_addr = 32'h400; bus.d_we = 1'b0; bus.d_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.m_req !== 1'b1) begin errors++; $display("FAIL rstbusy_in_busy got %b want 1", bus.m_req); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.m_req, bus.m_we, bus.i_ack, bus.d_ack, bus.err} !== 5'b0) begin errors++; $display("FAIL rstbusy_ctrl got %b want 00000", {bus.m_req, bus.m_we, bus.i_ack, bus.d_ack, bus.err}); end
        checks++; if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin errors++; $display("FAIL rstbusy_data got %h want 0", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata}); end
        bus.d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rstbusy_no_ack got %0d want 0", acks); end
        grant_q.delete();
        mem_mode = 1; fix_wait = 1; fix_data = 32'h0B0B0046;
        bus.i_addr = 32'h44; bus.i_req = 1'b1;
        wait_any_ack(40, lat, which);
        checks++; if (which !== 1 || lat !== 3 || bus.i_rdata !== 32'h0B0B0046) begin errors++; $display("FAIL rstbusy_refetch got port %0d lat %0d data %h want 1 3 0b0b0046", which, lat, bus.i_rdata); end
        bus.i_req = 1'b0;
        grant_q.delete();
        @(negedge clk);
    endtask

    // Randomized traffic against a transaction-level model: grant order from
    // the round-robin rule, latency from the memory's wait, rdata from the
    // memory contents or the error word.
    task automatic test_random();
        logic [31:0] m_i, m_d, m_wd;
        int last;
        bit in_resp;
        apply_reset();
        m_i = '0; m_d = '0; m_wd = '0; last = 1; in_resp = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int unsigned pick;
            int ri, rq, mode, gap, first, n;
            logic [31:0] ia, da, wd;
            logic we;
            pick = $urandom_range(1, 3);
            ri = int'(pick & 1); rq = int'((pick >> 1) & 1);
            mode = ($urandom_range(0, 7) == 0) ? 2 : 0;
            gap = in_resp ? int'($urandom_range(0, 1)) : 1;
            if (gap != 0) @(negedge clk);
            ia = $urandom; da = $urandom; wd = $urandom; we = 1'($urandom_range(0, 1));
            mem_mode = mode;
            bus.i_addr = ia; bus.i_req = 1'(ri);
            bus.d_addr = da; bus.d_we = we; bus.d_wdata = wd; bus.d_req = 1'(rq);
            if (ri != 0 && rq != 0) begin first = (last == 0) ? 1 : 0; n = 2; end
            else begin first = rq; n = 1; end
            for (int k = 0; k < n; k++) begin
                int port, busy, exp_lat, lat, which;
                logic [31:0] a, got_rd, exp_rd;
                logic [64:0] exp_rec, got_rec;
                logic got_err;
                port = (k == 0) ? first : 1 - first;
                a = (port != 0) ? da : ia;
                busy = (mode == 2) ? int'(TO) : int'(a[3:2]) + 1;
                exp_lat = 1 + busy + ((k == 1 || gap == 0) ? 1 : 0);
                wait_any_ack(60, lat, which);
                got_rd = (port != 0) ? bus.d_rdata : bus.i_rdata;
                got_err = bus.err;
                if (port == 0) begin
                    m_i = (mode == 2) ? ERRD : mem_word(ia);
                    exp_rd = m_i;
                    exp_rec = {1'b0, ia, m_wd};
                end else begin
                    if (mode == 2) m_d = ERRD;
                    else if (!we) m_d = mem_word(da);
                    exp_rd = m_d;
                    exp_rec = {we, da, wd};
                    m_wd = wd;
                end
                last = port;
                got_rec = (grant_q.size() > 0) ? grant_q.pop_front() : 'x;
                checks++; if (which !== port + 1 || lat !== exp_lat) begin errors++; $display("FAIL rand_ack it%0d got port %0d lat %0d want port %0d lat %0d", it, which, lat, port + 1, exp_lat); end
                checks++; if (got_rec !== exp_rec) begin errors++; $display("FAIL rand_cmd it%0d got %h want %h", it, got_rec, exp_rec); end
                checks++; if (got_rd !== exp_rd) begin errors++; $display("FAIL rand_rdata it%0d got %h want %h", it, got_rd, exp_rd); end
                checks++; if (got_err !== (mode == 2)) begin errors++; $display("FAIL rand_err it%0d got %b want %b", it, got_err, (mode == 2)); end
                if (port == 0) bus.i_req = 1'b0;
                else bus.d_req = 1'b0;
            end
            in_resp = 1'b1;
        end
        @(negedge clk);
        checks++; if (both_ack_cnt !== 0) begin errors++; $display("FAIL both_acks got %0d cycles want 0", both_ack_cnt); end
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL ack_with_m_req got %0d cycles want 0", overlap_cnt); end
        checks++; if (unstable_cnt !== 0) begin errors++; $display("FAIL busy_cmd_stable got %0d changes want 0", unstable_cnt); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_tie();
        test_store_wait();
        test_timeout();
        test_ack_at_limit();
        test_stray_ack();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
